rf_cmd_engine: RTL and testbench

- Command-driven client of the 2R1W register file: drives both read ports and the write port.
- Accepts register-to-register ops over a valid/ready interface, computes the result and writes it back through a registered write stage, with a bypass from that stage.
- Zero-fills the whole file after reset and on request.
- Sits between an instruction/command source and the register file.

---
 rtl/rf_cmd_engine.sv | 172 +++++++++++++++++
 tb/tb_rf_cmd_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_cmd_engine.sv
// Command engine for a 2R1W register file: zero-fill, ALU ops, registered
// write-back with a bypass from the pending write.
module rf_cmd_engine #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_rd,
    input  logic [ADDR_W-1:0] i_cmd_rs1,
    input  logic [ADDR_W-1:0] i_cmd_rs2,
    input  logic [WIDTH-1:0]  i_cmd_imm,
    output logic [ADDR_W-1:0] o_rd1_addr,
    input  logic [WIDTH-1:0]  i_rd1_data,
    output logic [ADDR_W-1:0] o_rd2_addr,
    input  logic [WIDTH-1:0]  i_rd2_data,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [WIDTH-1:0]  o_wr_data,
    output logic              o_wr_en,
    output logic              o_res_valid,
    output logic [ADDR_W-1:0] o_res_rd,
    output logic [WIDTH-1:0]  o_res_data,
    output logic              o_init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam bit                R0_ZERO   = (ZERO_R0 != 0);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                res_valid_q, res_valid_d;
    logic [ADDR_W-1:0]   res_rd_q, res_rd_d;
    logic [WIDTH-1:0]    res_data_q, res_data_d;

    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic [WIDTH-1:0]    result;
    logic                cmd_ready;
    logic                cmd_accept;
    logic                rd_writable;

    // Pending write sits in the write register; forward it to dependents.
    always_comb begin
        op_a = i_rd1_data;
        if (R0_ZERO && (i_cmd_rs1 == '0)) begin
            op_a = '0;
        end else if (wr_en_q && (wr_addr_q == i_cmd_rs1)) begin
            op_a = wr_data_q;
        end
    end

    always_comb begin
        op_b = i_rd2_data;
        if (R0_ZERO && (i_cmd_rs2 == '0)) begin
            op_b = '0;
        end else if (wr_en_q && (wr_addr_q == i_cmd_rs2)) begin
            op_b = wr_data_q;
        end
    end

    always_comb begin
        result = '0;
        unique case (i_cmd_op)
            OP_ADD:  result = op_a + op_b;
            OP_SUB:  result = op_a - op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_LDI:  result = i_cmd_imm;
            default: result = '0;
        endcase
    end

    assign rd_writable = !(R0_ZERO && (i_cmd_rd == '0));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        res_valid_d = 1'b0;
        res_rd_d    = res_rd_q;
        res_data_d  = res_data_q;
        cmd_ready   = 1'b0;
        cmd_accept  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                cmd_ready  = !i_clear;
                cmd_accept = i_cmd_valid && cmd_ready;
                if (cmd_accept) begin
                    wr_en_d     = rd_writable;
                    wr_addr_d   = i_cmd_rd;
                    wr_data_d   = result;
                    res_valid_d = 1'b1;
                    res_rd_d    = i_cmd_rd;
                    res_data_d  = result;
                end
                if (i_clear) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            res_valid_q <= res_valid_d;
            res_rd_q    <= res_rd_d;
            res_data_q  <= res_data_d;
        end
    end

    assign o_cmd_ready = cmd_ready;
    assign o_rd1_addr  = i_cmd_rs1;
    assign o_rd2_addr  = i_cmd_rs2;
    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_res_valid = res_valid_q;
    assign o_res_rd    = res_rd_q;
    assign o_res_data  = res_data_q;
    assign o_init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_rf_cmd_engine.sv
// Directed bench for rf_cmd_engine with a behavioural 2R1W register file
// preloaded with non-zero contents so the zero-fill is observable.
module tb_rf_cmd_engine;

    logic        clk;
    logic        rst_n;
    logic        i_clear;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_op;
    logic [4:0]  i_cmd_rd;
    logic [4:0]  i_cmd_rs1;
    logic [4:0]  i_cmd_rs2;
    logic [31:0] i_cmd_imm;
    logic [4:0]  o_rd1_addr;
    logic [31:0] i_rd1_data;
    logic [4:0]  o_rd2_addr;
    logic [31:0] i_rd2_data;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_wr_en;
    logic        o_res_valid;
    logic [4:0]  o_res_rd;
    logic [31:0] o_res_data;
    logic        o_init_done;

    logic [31:0] mem [32];
    logic        seed;

    int n_vec;
    int n_bad;

    rf_cmd_engine #(
        .WIDTH   (32),
        .DEPTH   (32),
        .ADDR_W  (5),
        .ZERO_R0 (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (i_clear),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_rd    (i_cmd_rd),
        .i_cmd_rs1   (i_cmd_rs1),
        .i_cmd_rs2   (i_cmd_rs2),
        .i_cmd_imm   (i_cmd_imm),
        .o_rd1_addr  (o_rd1_addr),
        .i_rd1_data  (i_rd1_data),
        .o_rd2_addr  (o_rd2_addr),
        .i_rd2_data  (i_rd2_data),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_wr_en     (o_wr_en),
        .o_res_valid (o_res_valid),
        .o_res_rd    (o_res_rd),
        .o_res_data  (o_res_data),
        .o_init_done (o_init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (seed) begin
            for (int k = 0; k < 32; k++) begin
                mem[k] <= 32'hA5A5_0000 | 32'(k);
            end
        end else if (o_wr_en) begin
            mem[o_wr_addr] <= o_wr_data;
        end
    end

    assign i_rd1_data = mem[o_rd1_addr];
    assign i_rd2_data = mem[o_rd2_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic fill_check(input int clr_at);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("fill_en[%0d]", i), 32'(o_wr_en), 32'd1);
            chk($sformatf("fill_addr[%0d]", i), 32'(o_wr_addr), 32'(i));
            chk($sformatf("fill_data[%0d]", i), o_wr_data, 32'd0);
            chk($sformatf("fill_resv[%0d]", i), 32'(o_res_valid), 32'd0);
            chk($sformatf("fill_rdy[%0d]", i), 32'(o_cmd_ready),
                32'(i == 31));
            chk($sformatf("fill_done[%0d]", i), 32'(o_init_done),
                32'(i == 31));
            i_clear = (i == clr_at);
        end
    endtask

    task automatic cmd(input string tag, input logic [1:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [31:0] exp, input logic wen);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_rd    = rd;
        i_cmd_rs1   = rs1;
        i_cmd_rs2   = rs2;
        i_cmd_imm   = imm;
        @(posedge clk);
        #1;
        chk({tag, "_resv"}, 32'(o_res_valid), 32'd1);
        chk({tag, "_resrd"}, 32'(o_res_rd), 32'(rd));
        chk({tag, "_resdata"}, o_res_data, exp);
        chk({tag, "_wen"}, 32'(o_wr_en), 32'(wen));
        if (wen) begin
            chk({tag, "_waddr"}, 32'(o_wr_addr), 32'(rd));
            chk({tag, "_wdata"}, o_wr_data, exp);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        seed        = 1'b1;
        rst_n       = 1'b0;
        i_clear     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'b00;
        i_cmd_rd    = 5'd0;
        i_cmd_rs1   = 5'd0;
        i_cmd_rs2   = 5'd0;
        i_cmd_imm   = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        seed = 1'b0;
        chk("rst_wen", 32'(o_wr_en), 32'd0);
        chk("rst_waddr", 32'(o_wr_addr), 32'd0);
        chk("rst_wdata", o_wr_data, 32'd0);
        chk("rst_resv", 32'(o_res_valid), 32'd0);
        chk("rst_resrd", 32'(o_res_rd), 32'd0);
        chk("rst_resdata", o_res_data, 32'd0);
        chk("rst_done", 32'(o_init_done), 32'd0);
        chk("rst_rdy", 32'(o_cmd_ready), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        fill_check(-1);

        // r31 zero write still pending: must be bypassed, not the stale 0xA5A5001F
        cmd("add_r31", 2'b00, 5'd9, 5'd31, 5'd31, 32'd0, 32'd0, 1'b1);
        cmd("ldi_r1", 2'b11, 5'd1, 5'd3, 5'd4, 32'd5, 32'd5, 1'b1);
        cmd("ldi_r2", 2'b11, 5'd2, 5'd0, 5'd0, 32'd7, 32'd7, 1'b1);
        cmd("add_r3", 2'b00, 5'd3, 5'd1, 5'd2, 32'd0, 32'd12, 1'b1);
        cmd("sub_r4", 2'b01, 5'd4, 5'd1, 5'd2, 32'd0, 32'hFFFF_FFFE, 1'b1);
        cmd("xor_r5", 2'b10, 5'd5, 5'd1, 5'd2, 32'd0, 32'h2, 1'b1);
        cmd("ldi_r0", 2'b11, 5'd0, 5'd0, 5'd0, 32'd9, 32'd9, 1'b0);
        cmd("add_r6", 2'b00, 5'd6, 5'd0, 5'd1, 32'd0, 32'd5, 1'b1);
        cmd("add_r4r4", 2'b00, 5'd7, 5'd4, 5'd6, 32'd0, 32'd3, 1'b1);

        i_cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_wen", 32'(o_wr_en), 32'd0);
        chk("idle_resv", 32'(o_res_valid), 32'd0);

        i_clear     = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'b00;
        i_cmd_rd    = 5'd7;
        i_cmd_rs1   = 5'd1;
        i_cmd_rs2   = 5'd2;
        #1;
        chk("clr_rdy", 32'(o_cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("clr_resv", 32'(o_res_valid), 32'd0);
        chk("clr_wen", 32'(o_wr_en), 32'd0);
        chk("clr_done", 32'(o_init_done), 32'd0);
        chk("clr_rdy_init", 32'(o_cmd_ready), 32'd0);
        i_clear     = 1'b0;
        i_cmd_valid = 1'b0;
        fill_check(5);

        cmd("xor_r8", 2'b10, 5'd8, 5'd1, 5'd2, 32'd0, 32'd0, 1'b1);
        i_cmd_valid = 1'b0;

        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_addr", 32'(o_wr_addr), 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wen", 32'(o_wr_en), 32'd0);
        chk("arst_waddr", 32'(o_wr_addr), 32'd0);
        chk("arst_done", 32'(o_init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_check(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
